byte_nibble_serializer: RTL and testbench

Stream stage that accepts 8-bit bytes over a valid/ready handshake and emits each byte as two 4-bit nibbles, upper nibble `[7:4]` first by default. It sits downstream of byte-producing logic and feeds nibble-wide consumers, replacing static `[7:4]` slicing with a flow-controlled, full-throughput serializer. A two-byte internal store sustains one nibble per cycle under continuous input.

---
 rtl/nib_pkg.sv | 29 ++
 rtl/byte_skid.sv | 76 +++++++
 rtl/byte_nibble_serializer.sv | 83 ++++++++
 tb/tb_byte_nibble_serializer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/nib_pkg.sv
// nib_pkg
// Shared definitions for the byte-to-nibble serializer slice.
// Holds the data widths, the output phase encoding and a helper that
// picks which nibble of a byte goes out in a given phase.
package nib_pkg;

    localparam int NIB_W  = 4;
    localparam int BYTE_W = 8;

    // The two output phases of one byte.
    typedef enum logic {
        PH_FIRST  = 1'b0,
        PH_SECOND = 1'b1
    } phase_e;

    // Returns the nibble of byte_val that is emitted in phase ph.
    // With hi_first set, the upper nibble goes out in PH_FIRST.
    // Without it, the upper nibble goes out in PH_SECOND.
    function automatic logic [NIB_W-1:0] sel_nib(
        input logic [BYTE_W-1:0] byte_val,
        input logic              hi_first,
        input phase_e            ph
    );
        logic take_hi;
        take_hi = hi_first ^ (ph == PH_SECOND);
        return take_hi ? byte_val[BYTE_W-1 -: NIB_W] : byte_val[NIB_W-1:0];
    endfunction

endpackage

// File: rtl/byte_skid.sv
// byte_skid
// Two-entry byte store. cur is the byte being serialized and nxt is the
// skid byte that was accepted while cur was still busy.
// Ports:
//   clk, reset_n - clock and asynchronous active-low reset
//   in_data      - incoming byte
//   load         - an input handshake happens this cycle
//   complete     - the second nibble of cur is taken this cycle
//   cur, cur_v   - current byte and its valid bit
//   nxt_v        - skid entry occupied
module byte_skid
    import nib_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              load,
    input  logic              complete,
    output logic [BYTE_W-1:0] cur,
    output logic              cur_v,
    output logic              nxt_v
);

    logic [BYTE_W-1:0] cur_q, cur_d;
    logic [BYTE_W-1:0] nxt_q, nxt_d;
    logic              cur_v_q, cur_v_d;
    logic              nxt_v_q, nxt_v_d;

    // When a byte completes, refill cur from the skid entry first, then
    // from a same-cycle input (bypass), otherwise cur empties.
    // The top level only asserts load while nxt is empty. A completion
    // with nxt full therefore never needs to accept a new byte as well.
    always_comb begin
        cur_d   = cur_q;
        nxt_d   = nxt_q;
        cur_v_d = cur_v_q;
        nxt_v_d = nxt_v_q;
        if (complete) begin
            if (nxt_v_q) begin
                cur_d   = nxt_q;
                nxt_v_d = 1'b0;
            end else if (load) begin
                cur_d = in_data;
            end else begin
                cur_v_d = 1'b0;
            end
        end else if (load) begin
            if (!cur_v_q) begin
                cur_d   = in_data;
                cur_v_d = 1'b1;
            end else begin
                nxt_d   = in_data;
                nxt_v_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_q   <= '0;
            nxt_q   <= '0;
            cur_v_q <= 1'b0;
            nxt_v_q <= 1'b0;
        end else begin
            cur_q   <= cur_d;
            nxt_q   <= nxt_d;
            cur_v_q <= cur_v_d;
            nxt_v_q <= nxt_v_d;
        end
    end

    assign cur   = cur_q;
    assign cur_v = cur_v_q;
    assign nxt_v = nxt_v_q;

endmodule

// File: rtl/byte_nibble_serializer.sv
// byte_nibble_serializer
// Accepts bytes over valid/ready and emits each byte as two nibbles over
// valid/ready. By default the upper nibble is emitted first.
// The two-byte store sustains one nibble per cycle.
// Ports:
//   HI_FIRST             - 1: [7:4] then [3:0]; 0: [3:0] then [7:4]
//   clk, reset_n         - clock and asynchronous active-low reset
//   in_valid/in_ready    - byte input handshake, in_data carries the byte
//   out_valid/out_ready  - nibble output handshake, out_nib carries it
//   out_last             - out_nib is the second nibble of its byte
//   byte_cnt             - fully emitted bytes, wraps at 256
module byte_nibble_serializer
    import nib_pkg::*;
#(
    parameter bit HI_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NIB_W-1:0]  out_nib,
    output logic              out_last,
    output logic [7:0]        byte_cnt
);

    phase_e            phase_q, phase_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [BYTE_W-1:0] cur;
    logic              cur_v;
    logic              nxt_v;
    logic              in_hs;
    logic              out_hs;
    logic              complete;

    assign in_ready  = !nxt_v;
    assign out_valid = cur_v;
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = cur_v && out_ready;
    assign complete  = out_hs && (phase_q == PH_SECOND);

    byte_skid u_skid (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_data  (in_data),
        .load     (in_hs),
        .complete (complete),
        .cur      (cur),
        .cur_v    (cur_v),
        .nxt_v    (nxt_v)
    );

    // The phase toggles on every output handshake.
    // A completed byte therefore always leaves the phase at PH_FIRST.
    // A freshly loaded byte starts in PH_FIRST without extra logic.
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        if (out_hs) begin
            phase_d = (phase_q == PH_FIRST) ? PH_SECOND : PH_FIRST;
        end
        if (complete) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= PH_FIRST;
            cnt_q   <= 8'h00;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_nib  = sel_nib(cur, HI_FIRST, phase_q);
    assign out_last = (phase_q == PH_SECOND);
    assign byte_cnt = cnt_q;

endmodule

// File: tb/tb_byte_nibble_serializer.sv
// tb_byte_nibble_serializer
// Drives two serializers (HI_FIRST = 1 and HI_FIRST = 0) with shared
// inputs. It compares both serializers against a queue-based model of
// bytes held and nibbles emitted.
module tb_byte_nibble_serializer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b0;

    logic       in_ready_h, out_valid_h, out_last_h;
    logic [3:0] out_nib_h;
    logic [7:0] byte_cnt_h;
    logic       in_ready_l, out_valid_l, out_last_l;
    logic [3:0] out_nib_l;
    logic [7:0] byte_cnt_l;

    int checks = 0;
    int errors = 0;

    // Model state: bytes accepted but not fully emitted, oldest first.
    logic [7:0] mq[$];
    int         nib_idx = 0;
    logic [7:0] mcnt = 8'h00;
    logic       last_in_hs = 1'b0;

    always #5 clk = ~clk;

    byte_nibble_serializer #(.HI_FIRST(1'b1)) dut_hi (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_h),
        .in_data   (in_data),
        .out_valid (out_valid_h),
        .out_ready (out_ready),
        .out_nib   (out_nib_h),
        .out_last  (out_last_h),
        .byte_cnt  (byte_cnt_h)
    );

    byte_nibble_serializer #(.HI_FIRST(1'b0)) dut_lo (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_l),
        .in_data   (in_data),
        .out_valid (out_valid_l),
        .out_ready (out_ready),
        .out_nib   (out_nib_l),
        .out_last  (out_last_l),
        .byte_cnt  (byte_cnt_l)
    );

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs at the falling edge and checks outputs
    // against the model. It then advances the model to the state it will
    // hold after the next rising edge.
    task automatic applyStimulus(input logic iv, input logic [7:0] d, input logic ordy);
        logic       m_ready, m_valid, in_hs, out_hs;
        logic [7:0] front;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        m_ready = (mq.size() < 2);
        m_valid = (mq.size() > 0);
        checkOutput("in_ready_hi", in_ready_h, m_ready);
        checkOutput("in_ready_lo", in_ready_l, m_ready);
        checkOutput("out_valid_hi", out_valid_h, m_valid);
        checkOutput("out_valid_lo", out_valid_l, m_valid);
        checkOutput("byte_cnt_hi", byte_cnt_h, mcnt);
        checkOutput("byte_cnt_lo", byte_cnt_l, mcnt);
        if (m_valid) begin
            front = mq[0];
            checkOutput("out_nib_hi", out_nib_h, (nib_idx == 0) ? front[7:4] : front[3:0]);
            checkOutput("out_nib_lo", out_nib_l, (nib_idx == 0) ? front[3:0] : front[7:4]);
            checkOutput("out_last_hi", out_last_h, nib_idx == 1);
            checkOutput("out_last_lo", out_last_l, nib_idx == 1);
        end
        in_hs  = iv && m_ready;
        out_hs = ordy && m_valid;
        if (out_hs) begin
            nib_idx++;
            if (nib_idx == 2) begin
                void'(mq.pop_front());
                nib_idx = 0;
                mcnt    = mcnt + 8'd1;
            end
        end
        if (in_hs) mq.push_back(d);
        last_in_hs = in_hs;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && mq.size() > 0; i++) applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("drain_empty", mq.size(), 0);
        applyStimulus(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int sent;
        // Power-on reset and idle.
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", in_ready_h, 1);
        checkOutput("rst_out_valid", out_valid_h, 0);
        checkOutput("rst_nib_noX", $isunknown(out_nib_h), 0);
        checkOutput("rst_nib_zero", out_nib_h, 4'h0);
        checkOutput("rst_out_last", out_last_h, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, 1'b0);

        // Single byte 8'hF0 with the consumer ready.
        applyStimulus(1'b1, 8'hF0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("f0_cnt", byte_cnt_h, 8'd1);

        // Continuous stream: no output bubble, in_ready alternates.
        for (int i = 0; i < 4; ) begin
            applyStimulus(1'b1, 8'h12 + 8'(i) * 8'h22, 1'b1);
            if (last_in_hs) i++;
        end
        drain();
        checkOutput("stream_cnt", byte_cnt_h, 8'd5);

        // Stalled consumer: A5 then 3C held, then released.
        applyStimulus(1'b1, 8'hA5, 1'b0);
        applyStimulus(1'b1, 8'h3C, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("stall_nib", out_nib_h, 4'hA);
        checkOutput("stall_full", in_ready_h, 0);
        drain();

        // Asynchronous reset while the first nibble of 9E is showing.
        applyStimulus(1'b1, 8'h9E, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("arst_out_valid", out_valid_h, 0);
        checkOutput("arst_byte_cnt", byte_cnt_h, 8'h00);
        checkOutput("arst_in_ready", in_ready_h, 1);
        mq.delete();
        nib_idx = 0;
        mcnt    = 8'h00;
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b1);

        // 256 bytes: counter wraps back to zero.
        sent = 0;
        while (sent < 256) begin
            applyStimulus(1'b1, $urandom_range(0, 255), 1'b1);
            if (last_in_hs) sent++;
        end
        drain();
        checkOutput("cnt_wrap", byte_cnt_h, 8'h00);

        // Random traffic on both sides.
        for (int i = 0; i < 500; i++)
            applyStimulus($urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 3) != 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
